// File: rtl/dec_wb_ctl_pkg.sv
// Shared constants for the decode/writeback control slice.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package dec_wb_ctl_pkg;

    // Register file geometry
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    // Writeback channel roles; the FPU always owns the highest-index channel
    localparam int CH_CSR  = 0;
    localparam int CH_INT  = 1;
    localparam int DEF_NCH = 3;
    localparam int CH_FPU  = DEF_NCH - 1;

    // FPU channel index for an arbitrary channel count
    function automatic int ch_fpu_idx(input int nch);
        return nch - 1;
    endfunction

endpackage

// File: rtl/dec_wb_ctl_wb_prio_arb.sv
// Fixed-priority writeback arbiter: lowest-index requester wins.
// Latency: purely combinational, grant in the same cycle as request.
// Backpressure: losers see gnt=0 and must hold their request until granted.
module wb_prio_arb #(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt
);

    logic taken;

    // Walk from channel 0 upward; first requester masks all later ones
    always_comb begin
        gnt   = '0;
        taken = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            gnt[i] = req[i] & ~taken;
            taken  = taken | req[i];
        end
    end

endmodule

// File: rtl/dec_wb_ctl.sv
// Issue scoreboard plus writeback arbitration into a registered RF write port.
// Latency: issue_ready combinational; RF write one cycle after grant; scoreboard updates next edge.
// Backpressure: issue_ready drops on hazards/full/flush; wb channels stall until wb_ready.
module dec_wb_ctl
    import dec_wb_ctl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NCH     = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_rd,
    input  logic [4:0]                   issue_rs1,
    input  logic [4:0]                   issue_rs2,
    input  logic                         issue_rs1_en,
    input  logic                         issue_rs2_en,
    input  logic                         issue_long,
    output logic                         issue_ready,
    input  logic [NCH-1:0]               wb_valid,
    input  logic [5*NCH-1:0]             wb_rd,
    input  logic [XLEN*NCH-1:0]          wb_data,
    output logic [NCH-1:0]               wb_ready,
    output logic                         rf_wen,
    output logic [4:0]                   rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic [31:0]                  sb_busy,
    output logic [$clog2(MAX_OUT+1)-1:0] out_cnt
);

    localparam int              FPU     = ch_fpu_idx(NCH);
    localparam int              CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUT);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [NREG-1:0]   sb_busy_q,  sb_busy_d;
    logic [CW-1:0]     out_cnt_q,  out_cnt_d;
    logic              rf_wen_q,   rf_wen_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    logic [NCH-1:0]    arb_gnt;
    logic              hazard;
    logic              lng_set;
    logic              fpu_clr;
    logic              wb_any;
    logic [REG_AW-1:0] fpu_rd;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    wb_prio_arb #(
        .NCH (NCH)
    ) u_wb_prio_arb (
        .req (wb_valid),
        .gnt (arb_gnt)
    );

    // Grants are suppressed while held in reset
    assign wb_ready = rst_l ? arb_gnt : '0;
    assign wb_any   = |wb_ready;
    assign fpu_rd   = wb_rd[FPU*REG_AW +: REG_AW];

    // RAW on either source, WAW on destination, or no room for another long op
    always_comb begin
        hazard = 1'b0;
        if (issue_rs1_en && sb_busy_q[issue_rs1]) hazard = 1'b1;
        if (issue_rs2_en && sb_busy_q[issue_rs2]) hazard = 1'b1;
        if (sb_busy_q[issue_rd])                  hazard = 1'b1;
        if (issue_long && (out_cnt_q == CNT_MAX)) hazard = 1'b1;
    end

    assign issue_ready = rst_l & ~flush & ~hazard;

    // x0 is never tracked, so a long op targeting it leaves no footprint
    assign lng_set = issue_valid & issue_ready & issue_long & (issue_rd != '0);
    // Only retire an FPU write that we actually counted (e.g. not one issued before a reset)
    assign fpu_clr = wb_ready[FPU] & sb_busy_q[fpu_rd];

    // Steer the granted channel's address and data into the write stage
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wb_ready[i]) begin
                sel_rd   = wb_rd[i*REG_AW +: REG_AW];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard and in-flight counter next state; flush overrides same-cycle set/clear
    always_comb begin
        sb_busy_d = sb_busy_q;
        out_cnt_d = out_cnt_q;
        if (fpu_clr) sb_busy_d[fpu_rd]  = 1'b0;
        if (lng_set) sb_busy_d[issue_rd] = 1'b1;
        if (lng_set && !fpu_clr && (out_cnt_q != CNT_MAX)) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
        end else if (fpu_clr && !lng_set && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CNT_ONE;
        end
        if (flush) begin
            sb_busy_d = '0;
            out_cnt_d = '0;
        end
        sb_busy_d[0] = 1'b0;
    end

    // Registered RF write stage; a write to x0 is dropped, flush does not touch it
    always_comb begin
        rf_wen_d   = wb_any & (sel_rd != '0);
        rf_waddr_d = wb_any ? sel_rd   : rf_waddr_q;
        rf_wdata_d = wb_any ? sel_data : rf_wdata_q;
    end

    // State flops with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sb_busy_q  <= '0;
            out_cnt_q  <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            sb_busy_q  <= sb_busy_d;
            out_cnt_q  <= out_cnt_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign sb_busy  = sb_busy_q;
    assign out_cnt  = out_cnt_q;
    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_dec_wb_ctl.sv
// Directed bench for dec_wb_ctl with hand-computed expectations.
// Latency: inputs driven 1ns after posedge, outputs sampled before next edge.
// Backpressure: exercises issue stalls and wb channel stalls.
module tb_dec_wb_ctl;

    logic        clk;
    logic        rst_l;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_rs1_en, issue_rs2_en, issue_long;
    logic        issue_ready;
    logic [2:0]  wb_valid;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;
    logic [2:0]  wb_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] sb_busy;
    logic [2:0]  out_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    dec_wb_ctl #(
        .XLEN    (32),
        .NCH     (3),
        .MAX_OUT (4)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rs1_en (issue_rs1_en),
        .issue_rs2_en (issue_rs2_en),
        .issue_long   (issue_long),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sb_busy      (sb_busy),
        .out_cnt      (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_issue();
        issue_valid  = 1'b0;
        issue_rd     = '0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rs1_en = 1'b0;
        issue_rs2_en = 1'b0;
        issue_long   = 1'b0;
    endtask

    task automatic idle_wb();
        wb_valid = '0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_en,
                               input logic [4:0] rs2, input logic rs2_en, input logic lng);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_rs1    = rs1;
        issue_rs1_en = rs1_en;
        issue_rs2    = rs2;
        issue_rs2_en = rs2_en;
        issue_long   = lng;
    endtask

    task automatic drive_wb(input int ch, input logic [4:0] rd, input logic [31:0] d);
        wb_valid[ch]         = 1'b1;
        wb_rd[ch*5 +: 5]     = rd;
        wb_data[ch*32 +: 32] = d;
    endtask

    // Watchdog: the run is straight-line, this only guards against a stuck simulator
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l = 1'b0;
        flush = 1'b0;
        idle_issue();
        idle_wb();

        // Reset: outputs cleared, handshakes held low even with requests present
        drive_issue(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        wb_valid = 3'b111;
        #22;
        check_eq("rst_sb_busy",  sb_busy,  0);
        check_eq("rst_out_cnt",  out_cnt,  0);
        check_eq("rst_rf_wen",   rf_wen,   0);
        check_eq("rst_rf_waddr", rf_waddr, 0);
        check_eq("rst_rf_wdata", rf_wdata, 0);
        check_eq("rst_issue_rdy", issue_ready, 0);
        check_eq("rst_wb_ready", wb_ready, 0);
        idle_issue();
        idle_wb();
        #2;
        rst_l = 1'b1;
        tick();

        // RAW stall on a long op until its FPU writeback is granted
        drive_issue(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        settle();
        check_eq("raw_long_rdy", issue_ready, 1);
        tick();
        check_eq("raw_sb_set", sb_busy, 32'h0000_0020);
        check_eq("raw_cnt1",   out_cnt, 1);
        drive_issue(5'd8, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        settle();
        check_eq("raw_stall0", issue_ready, 0);
        tick();
        check_eq("raw_stall1", issue_ready, 0);
        drive_wb(2, 5'd5, 32'hF00D_0005);
        settle();
        check_eq("raw_fpu_gnt", wb_ready, 3'b100);
        check_eq("raw_stall2",  issue_ready, 0);
        tick();
        idle_wb();
        settle();
        check_eq("raw_rdy_after", issue_ready, 1);
        check_eq("raw_cnt0",      out_cnt, 0);
        check_eq("raw_sb_clr",    sb_busy, 0);
        check_eq("raw_rf_wen",    rf_wen, 1);
        check_eq("raw_rf_waddr",  rf_waddr, 5);
        check_eq("raw_rf_wdata",  rf_wdata, 32'hF00D_0005);
        tick();
        idle_issue();

        // Three channels at once: serviced 0,1,2, each RF write a cycle later
        drive_wb(0, 5'd3, 32'hAAAA_0003);
        drive_wb(1, 5'd4, 32'hBBBB_0004);
        drive_wb(2, 5'd6, 32'hCCCC_0006);
        settle();
        check_eq("arb_gnt0", wb_ready, 3'b001);
        tick();
        check_eq("arb_rf0_wen",  rf_wen, 1);
        check_eq("arb_rf0_addr", rf_waddr, 3);
        check_eq("arb_rf0_data", rf_wdata, 32'hAAAA_0003);
        wb_valid[0] = 1'b0;
        settle();
        check_eq("arb_gnt1", wb_ready, 3'b010);
        tick();
        check_eq("arb_rf1_addr", rf_waddr, 4);
        check_eq("arb_rf1_data", rf_wdata, 32'hBBBB_0004);
        wb_valid[1] = 1'b0;
        settle();
        check_eq("arb_gnt2", wb_ready, 3'b100);
        tick();
        check_eq("arb_rf2_addr", rf_waddr, 6);
        check_eq("arb_rf2_data", rf_wdata, 32'hCCCC_0006);
        check_eq("arb_cnt_hold", out_cnt, 0);
        idle_wb();
        tick();
        check_eq("arb_rf_idle", rf_wen, 0);

        // Fill to MAX_OUT, then the fifth long op waits for one retirement
        for (int r = 1; r <= 4; r++) begin
            drive_issue(5'(r), 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            settle();
            check_eq("full_fill_rdy", issue_ready, 1);
            tick();
        end
        idle_issue();
        settle();
        check_eq("full_cnt4", out_cnt, 4);
        check_eq("full_sb",   sb_busy, 32'h0000_001E);
        drive_issue(5'd20, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        settle();
        check_eq("full_rs2_haz", issue_ready, 0);
        drive_issue(5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        check_eq("full_waw_haz", issue_ready, 0);
        drive_issue(5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive_wb(2, 5'd1, 32'h0000_0111);
        settle();
        check_eq("full_5th_stall", issue_ready, 0);
        check_eq("full_wb_gnt",    wb_ready, 3'b100);
        tick();
        idle_wb();
        settle();
        check_eq("full_cnt3",    out_cnt, 3);
        check_eq("full_sb_clr1", sb_busy, 32'h0000_001C);
        check_eq("full_5th_rdy", issue_ready, 1);
        tick();
        idle_issue();
        check_eq("full_cnt4b",   out_cnt, 4);
        check_eq("full_sb_set7", sb_busy, 32'h0000_009C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("full_flush_cnt", out_cnt, 0);
        check_eq("full_flush_sb",  sb_busy, 0);

        // Long op to x0 leaves no trace; writeback to x0 suppresses rf_wen
        drive_issue(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        settle();
        check_eq("x0_rdy", issue_ready, 1);
        tick();
        idle_issue();
        check_eq("x0_sb",  sb_busy, 0);
        check_eq("x0_cnt", out_cnt, 0);
        drive_wb(1, 5'd0, 32'h1234_5678);
        tick();
        idle_wb();
        check_eq("x0_rf_wen", rf_wen, 0);

        // FPU writeback for an untracked register must not underflow the counter
        drive_wb(2, 5'd9, 32'h0000_0909);
        tick();
        idle_wb();
        check_eq("uf_cnt",    out_cnt, 0);
        check_eq("uf_rf_wen", rf_wen, 1);
        check_eq("uf_rf_adr", rf_waddr, 9);

        // Flush with a same-cycle long issue and a grant in flight
        drive_issue(5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        drive_issue(5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        check_eq("fl_cnt2", out_cnt, 2);
        drive_issue(5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive_wb(1, 5'd13, 32'hDEAD_000D);
        flush = 1'b1;
        settle();
        check_eq("fl_rdy0", issue_ready, 0);
        tick();
        flush = 1'b0;
        idle_issue();
        idle_wb();
        check_eq("fl_sb",      sb_busy, 0);
        check_eq("fl_cnt",     out_cnt, 0);
        check_eq("fl_rf_wen",  rf_wen, 1);
        check_eq("fl_rf_addr", rf_waddr, 13);

        // Same-cycle long issue and FPU retirement: count unchanged, both bits updated
        drive_issue(5'd14, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        drive_issue(5'd15, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive_wb(2, 5'd14, 32'h0000_0E0E);
        tick();
        idle_wb();
        check_eq("sim_cnt", out_cnt, 1);
        check_eq("sim_sb",  sb_busy, 32'h0000_8000);

        // Asynchronous reset mid-run with three long ops outstanding
        drive_issue(5'd16, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        drive_issue(5'd17, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive_wb(0, 5'd21, 32'h0000_2121);
        tick();
        idle_issue();
        idle_wb();
        check_eq("ar_cnt3",   out_cnt, 3);
        check_eq("ar_rf_pre", rf_wen, 1);
        #2;
        rst_l = 1'b0;
        drive_wb(2, 5'd2, 32'h0000_0202);
        #1;
        check_eq("ar_sb",       sb_busy, 0);
        check_eq("ar_cnt",      out_cnt, 0);
        check_eq("ar_rf_wen",   rf_wen, 0);
        check_eq("ar_rf_waddr", rf_waddr, 0);
        check_eq("ar_rf_wdata", rf_wdata, 0);
        check_eq("ar_wb_rdy",   wb_ready, 0);
        tick();
        rst_l = 1'b1;
        settle();
        check_eq("ar_post_gnt", wb_ready, 3'b100);
        tick();
        idle_wb();
        check_eq("ar_rf_wen2",  rf_wen, 1);
        check_eq("ar_rf_addr2", rf_waddr, 2);
        check_eq("ar_rf_data2", rf_wdata, 32'h0000_0202);
        check_eq("ar_cnt_stay", out_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_wb_ctl.md
DEC_WB_CTL -- requirements
Module: dec_wb_ctl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter NCH, default 3, meaning writeback channel count; channel 0 = CSR read, 1 = integer result, NCH-1 = FPU result.
REQ-003 SHALL have parameter MAX_OUT, default 4, meaning maximum in-flight long-latency (FPU) writes.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- flush  in  1  clear scoreboard and in-flight count.
- issue_valid  in  1  decoded instruction present.
- issue_rd / issue_rs1 / issue_rs2  in  5 each  register addresses.
- issue_rs1_en / issue_rs2_en  in  1 each  source read enables.
- issue_long  in  1  destination written later by FPU channel.
- issue_ready  out  1  issue accepted this cycle.
- wb_valid  in  NCH  per-channel writeback request.
- wb_rd  in  5*NCH  per-channel destination.
- wb_data  in  XLEN*NCH  per-channel data.
- wb_ready  out  NCH  per-channel grant.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- sb_busy  out  32  scoreboard bit per register.
- out_cnt  out  $clog2(MAX_OUT+1)  in-flight long writes.

Function
REQ-005 SHALL hold one scoreboard bit per register; bit 0 SHALL always read 0.
REQ-006 SHALL deassert issue_ready combinationally on any hazard: issue_rs1_en & sb_busy[issue_rs1], issue_rs2_en & sb_busy[issue_rs2], sb_busy[issue_rd] (WAW), issue_long & out_cnt==MAX_OUT, or flush=1.
REQ-007 An issue is accepted when issue_valid & issue_ready; if issue_long and issue_rd!=0, it SHALL set sb_busy[issue_rd] and increment out_cnt on the next edge.
REQ-008 Accepted issue_long with issue_rd==0 SHALL change neither sb_busy nor out_cnt.
REQ-009 SHALL grant fixed priority: lowest-index valid channel gets wb_ready=1; all others 0 and SHALL hold request and data stable until granted.
REQ-010 Granted write SHALL appear on rf_wen/rf_waddr/rf_wdata exactly one cycle after grant (registered stage); rf_wen=0 when no grant or when granted rd==0.
REQ-011 A grant on channel NCH-1 SHALL clear sb_busy[wb_rd] and decrement out_cnt on the next edge, only if that bit was set; otherwise out_cnt unchanged.
REQ-012 Simultaneous accepted long issue and FPU clear in one cycle SHALL leave out_cnt unchanged, with both bit updates applied (different registers, guaranteed by REQ-006).
REQ-013 flush SHALL clear all sb_busy and out_cnt on the next edge, override same-cycle set/clear, and not cancel a write already in the registered stage.
REQ-014 out_cnt SHALL never wrap; a decrement at 0 SHALL be ignored.
REQ-015 Writeback is unaffected by hazards; grants continue while issue_ready=0.

Reset
REQ-016 On rst_l=0, asynchronously: sb_busy=0, out_cnt=0, rf_wen=0, rf_waddr=0, rf_wdata=0.
REQ-017 While rst_l=0, issue_ready=0 and wb_ready=0.
REQ-018 Reset mid-operation SHALL discard in-flight scoreboard state; FPU writebacks after release write normally without touching out_cnt.

Structure
REQ-019 Channel index constants (CH_CSR=0, CH_INT=1, CH_FPU=NCH-1) and register-address width SHALL be in the shared FPU package.
REQ-020 Priority arbiter SHALL be one sub-module, wb_prio_arb, parametrised by NCH.

Verification
REQ-021 Long issue rd=5, then issue rs1=5 -> issue_ready=0 until FPU wb rd=5 granted; ready=1 the cycle after; out_cnt 1->0.
REQ-022 Channels 0,1,2 valid same cycle, rd=3,4,6 -> grants in order 0,1,2 over 3 cycles; rf writes rd 3,4,6 each one cycle after grant.
REQ-023 Four long issues rd=1..4 -> out_cnt=4; fifth long issue rd=7 -> issue_ready=0; one FPU wb rd=1 -> fifth accepted the next cycle.
REQ-024 Long issue rd=0 -> sb_busy=0, out_cnt=0; wb rd=0 granted -> rf_wen=0.
REQ-025 out_cnt=2, flush pulse with same-cycle long issue -> issue_ready=0, sb_busy=0, out_cnt=0 next cycle.
REQ-026 rst_l low mid-run with out_cnt=3 -> all outputs 0 immediately; after release, FPU wb rd=2 -> rf write rd=2, out_cnt stays 0.
